uart_rx_pkt_ctl: RTL

//  Packet-level controller behind the UART byte receiver. Consumes rx_data/rx_done_sig byte strobes.

---
 rtl/uart_rx_pkt_ctl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_pkt_ctl.sv
// Packet framer behind the UART byte receiver: SYNC, LEN, payload[LEN], CHK (XOR of LEN and payload).
// Good payloads are buffered and streamed out over valid/ready; errors are pulsed and latched.
module uart_rx_pkt_ctl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done_sig,
    output logic [7:0] o_out_data,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_out_last,
    output logic [7:0] o_pkt_len,
    output logic [7:0] o_pkt_cnt,
    output logic       o_err_pulse,
    output logic [2:0] o_err_code,
    output logic       o_busy
);

    localparam int unsigned PW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned GW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0]    MaxLen  = 8'(MAX_LEN);
    localparam logic [GW-1:0] GapLast = GW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ErrBadLen  = 3'd1;
    localparam logic [2:0] ErrBadChk  = 3'd2;
    localparam logic [2:0] ErrOverrun = 3'd3;
    localparam logic [2:0] ErrTimeout = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StPayload,
        StChk,
        StOut
    } state_e;

    state_e          r_state;
    logic [7:0]      r_len;
    logic [7:0]      r_chk;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [GW-1:0]   r_gap;
    logic [7:0]      r_out_data;
    logic            r_out_valid;
    logic            r_out_last;
    logic [7:0]      r_pkt_len;
    logic [7:0]      r_pkt_cnt;
    logic            r_err_pulse;
    logic [2:0]      r_err_code;
    logic [7:0]      r_buf [MAX_LEN];

    logic            w_gap_expired;
    logic            w_wr_last;
    logic            w_handshake;
    logic            w_buf_we;
    logic [PW-1:0]   w_rd_next;

    assign w_gap_expired = (r_gap == GapLast);
    assign w_wr_last     = (8'(r_wr_ptr) == r_len - 8'd1);
    assign w_handshake   = r_out_valid & i_out_ready;
    assign w_buf_we      = (r_state == StPayload) & i_rx_done_sig;
    assign w_rd_next     = r_rd_ptr + PW'(1);

    // Payload storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_wr_ptr[AW-1:0]] <= i_rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_len       <= '0;
            r_chk       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_gap       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pkt_len   <= '0;
            r_pkt_cnt   <= '0;
            r_err_pulse <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_gap <= '0;
                    if (i_rx_done_sig && i_rx_data == SYNC_BYTE) begin
                        r_state <= StLen;
                    end
                end
                StLen: begin
                    if (i_rx_done_sig) begin
                        r_gap <= '0;
                        if (i_rx_data == 8'd0 || i_rx_data > MaxLen) begin
                            r_err_pulse <= 1'b1;
                            r_err_code  <= ErrBadLen;
                            r_state     <= StIdle;
                        end else begin
                            r_len    <= i_rx_data;
                            r_chk    <= i_rx_data;
                            r_wr_ptr <= '0;
                            r_state  <= StPayload;
                        end
                    end else if (w_gap_expired) begin
                        r_err_pulse <= 1'b1;
                        r_err_code  <= ErrTimeout;
                        r_state     <= StIdle;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                StPayload: begin
                    if (i_rx_done_sig) begin
                        r_gap    <= '0;
                        r_chk    <= r_chk ^ i_rx_data;
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                        if (w_wr_last) begin
                            r_state <= StChk;
                        end
                    end else if (w_gap_expired) begin
                        r_err_pulse <= 1'b1;
                        r_err_code  <= ErrTimeout;
                        r_state     <= StIdle;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                StChk: begin
                    if (i_rx_done_sig) begin
                        r_gap <= '0;
                        if (i_rx_data == r_chk) begin
                            r_rd_ptr    <= '0;
                            r_out_data  <= r_buf[AW'(0)];
                            r_out_valid <= 1'b1;
                            r_out_last  <= (r_len == 8'd1);
                            r_pkt_len   <= r_len;
                            r_pkt_cnt   <= r_pkt_cnt + 8'd1;
                            r_state     <= StOut;
                        end else begin
                            r_err_pulse <= 1'b1;
                            r_err_code  <= ErrBadChk;
                            r_state     <= StIdle;
                        end
                    end else if (w_gap_expired) begin
                        r_err_pulse <= 1'b1;
                        r_err_code  <= ErrTimeout;
                        r_state     <= StIdle;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                StOut: begin
                    r_gap <= '0;
                    // Incoming bytes are dropped; streaming is unaffected.
                    if (i_rx_done_sig) begin
                        r_err_pulse <= 1'b1;
                        r_err_code  <= ErrOverrun;
                    end
                    if (w_handshake) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= StIdle;
                        end else begin
                            r_rd_ptr   <= w_rd_next;
                            r_out_data <= r_buf[w_rd_next[AW-1:0]];
                            r_out_last <= (8'(w_rd_next) == r_len - 8'd1);
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_pkt_len   = r_pkt_len;
    assign o_pkt_cnt   = r_pkt_cnt;
    assign o_err_pulse = r_err_pulse;
    assign o_err_code  = r_err_code;
    assign o_busy      = (r_state != StIdle);

endmodule
